// File: rtl/packet_checker_if.sv
// AXI-Stream beat bus between a packet source and packet_checker.
// The master drives data/keep/last/valid; the slave returns ready.
interface packet_checker_if #(
   parameter int DW = 512
);
   logic [DW-1:0]   tdata;
   logic [DW/8-1:0] tkeep;
   logic            tlast;
   logic            tvalid;
   logic            tready;

   modport master (
      output tdata,
      output tkeep,
      output tlast,
      output tvalid,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tkeep,
      input  tlast,
      input  tvalid,
      output tready
   );
endinterface

// File: rtl/packet_checker.sv
// packet_checker: AXI-Stream sink that verifies the rolling 16-bit data
// pattern, tkeep masks and packet boundaries produced by packet_gen against
// the fixed 8-entry length sequence, and counts packets and bad beats.
// tready can be throttled by a free-running LFSR to stress upstream logic.
module packet_checker #(
   parameter int          DW        = 512,
   parameter bit          BP_ENABLE = 1'b1,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int          CNT_W     = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   packet_checker_if.slave  axis_in,
   output logic [CNT_W-1:0] pkt_count,
   output logic [CNT_W-1:0] err_count,
   output logic             err_flag,
   output logic [1:0]       err_code
);
   localparam int DB     = DW / 8;
   localparam int LOG_DB = $clog2(DB);
   localparam int LANES  = DW / 16;
   // Wide enough for the longest packet (1021 bytes) expressed in bytes or beats.
   localparam int LW     = 11;

   localparam logic [1:0] CODE_DATA = 2'd1;
   localparam logic [1:0] CODE_KEEP = 2'd2;
   localparam logic [1:0] CODE_LEN  = 2'd3;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      lfsr_q, lfsr_d;
   logic [15:0]      exp_data_q, exp_data_d;
   logic [2:0]       idx_q, idx_d;
   logic [LW-1:0]    beat_q, beat_d;
   logic [CNT_W-1:0] pkt_q, pkt_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic             flag_q, flag_d;
   logic [1:0]       code_q, code_d;

   logic [LW-1:0]    len_bytes, whole_beats, part_bytes, total_beats;
   logic             last_beat;
   logic             bp_ok, tready_w, accept;
   logic [LANES-1:0] lane_ok;
   logic [DB-1:0]    exp_keep;
   logic             data_err, keep_err, len_err, any_err;
   logic [1:0]       first_code;

   // Fixed packet length sequence emitted by packet_gen, in bytes.
   function automatic logic [LW-1:0] plen(input logic [2:0] idx);
      logic [LW-1:0] l;
      case (idx)
         3'd0:    l = LW'(18);
         3'd1:    l = LW'(128);
         3'd2:    l = LW'(1021);
         3'd3:    l = LW'(205);
         3'd4:    l = LW'(12);
         3'd5:    l = LW'(127);
         3'd6:    l = LW'(329);
         3'd7:    l = LW'(256);
         default: l = LW'(18);
      endcase
      return l;
   endfunction

   // Beat geometry of the packet currently expected.
   always_comb begin
      len_bytes   = plen(idx_q);
      whole_beats = len_bytes >> LOG_DB;
      part_bytes  = len_bytes & LW'(DB - 1);
      total_beats = whole_beats + LW'(part_bytes != '0);
      last_beat   = (beat_q == total_beats);
   end

   // tready comes only from registered state gated by enable, never from tvalid,
   // so an enable drop silences the sink within the same cycle.
   assign bp_ok          = BP_ENABLE ? (lfsr_q[0] | lfsr_q[1]) : 1'b1;
   assign tready_w       = (state_q == RUN) & enable & bp_ok;
   assign axis_in.tready = tready_w;
   assign accept         = axis_in.tvalid & tready_w;

   // Every 16-bit lane carries the same counter value, kept bytes or not.
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign lane_ok[gi] = (axis_in.tdata[gi*16 +: 16] == exp_data_q);
      end
      // Only the final beat of a packet with a partial tail has a short keep mask.
      for (gi = 0; gi < DB; gi++) begin : g_keep
         assign exp_keep[gi] = !last_beat || (part_bytes == '0) || (LW'(gi) < part_bytes);
      end
   endgenerate

   assign data_err = ~&lane_ok;
   assign keep_err = (axis_in.tkeep != exp_keep);
   assign len_err  = (axis_in.tlast != last_beat);
   assign any_err  = data_err | keep_err | len_err;

   // Lowest-numbered failing check wins when several fail on one beat.
   always_comb begin
      first_code = 2'd0;
      if (len_err)  first_code = CODE_LEN;
      if (keep_err) first_code = CODE_KEEP;
      if (data_err) first_code = CODE_DATA;
   end

   // Next-state: run/idle control, packet tracking, LFSR and status counters.
   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      exp_data_d = exp_data_q;
      idx_d      = idx_q;
      beat_d     = beat_q;
      pkt_d      = pkt_q;
      err_d      = err_q;
      flag_d     = flag_q;
      code_d     = code_q;

      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d    = RUN;
               exp_data_d = 16'd1;
               idx_d      = 3'd0;
               beat_d     = LW'(1);
            end
         end
         RUN: begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            if (!enable) begin
               // A partial packet is abandoned; counters survive.
               state_d = IDLE;
            end else if (accept) begin
               exp_data_d = exp_data_q + 16'd1;
               if (axis_in.tlast) begin
                  beat_d = LW'(1);
                  idx_d  = idx_q + 3'd1;
                  if (pkt_q != '1) pkt_d = pkt_q + CNT_W'(1);
               end else if (last_beat) begin
                  // Missing tlast: resync to the next packet without counting it.
                  beat_d = LW'(1);
                  idx_d  = idx_q + 3'd1;
               end else begin
                  beat_d = beat_q + LW'(1);
               end
               if (any_err) begin
                  if (err_q != '1) err_d = err_q + CNT_W'(1);
                  if (!flag_q) begin
                     flag_d = 1'b1;
                     code_d = first_code;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         lfsr_q     <= LFSR_SEED;
         exp_data_q <= 16'd1;
         idx_q      <= 3'd0;
         beat_q     <= LW'(1);
         pkt_q      <= '0;
         err_q      <= '0;
         flag_q     <= 1'b0;
         code_q     <= 2'd0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         exp_data_q <= exp_data_d;
         idx_q      <= idx_d;
         beat_q     <= beat_d;
         pkt_q      <= pkt_d;
         err_q      <= err_d;
         flag_q     <= flag_d;
         code_q     <= code_d;
      end
   end

   assign pkt_count = pkt_q;
   assign err_count = err_q;
   assign err_flag  = flag_q;
   assign err_code  = code_q;
endmodule

// File: tb/tb_packet_checker.sv
// Bench for packet_checker: DW=64 with LFSR backpressure. A packet source
// generates the packet_gen pattern with deliberate faults; each driven beat
// pushes the status it should produce, and a monitor pops and compares once
// the DUT accepts that beat.
module tb_packet_checker;
   localparam int DW    = 64;
   localparam int KW    = DW / 8;
   localparam int LANES = DW / 16;
   localparam int CNT_W = 16;

   // Packet kinds produced by send_pkt.
   localparam int K_CLEAN    = 0;
   localparam int K_DATA     = 1;
   localparam int K_KEEP     = 2;
   localparam int K_EARLY    = 3;
   localparam int K_NOLAST   = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic [CNT_W-1:0] pkt_count;
   logic [CNT_W-1:0] err_count;
   logic             err_flag;
   logic [1:0]       err_code;

   packet_checker_if #(.DW(DW)) bus ();

   packet_checker #(
      .DW        (DW),
      .BP_ENABLE (1'b1),
      .LFSR_SEED (16'hACE1),
      .CNT_W     (CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .axis_in   (bus),
      .pkt_count (pkt_count),
      .err_count (err_count),
      .err_flag  (err_flag),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [CNT_W-1:0] pkt;
      logic [CNT_W-1:0] err;
      logic             flag;
      logic [1:0]       code;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mdl;
   logic [15:0] e_data;
   logic [2:0]  e_idx;
   int          total_n = 0;
   int          bad_n   = 0;
   logic        meas    = 1'b0;
   int          bp_cycles = 0;
   int          bp_low    = 0;
   int          idle_ready = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_n++;
      if (got !== exp) begin
         bad_n++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   function automatic int len_of(input logic [2:0] idx);
      int l;
      case (idx)
         3'd0: l = 18;
         3'd1: l = 128;
         3'd2: l = 1021;
         3'd3: l = 205;
         3'd4: l = 12;
         3'd5: l = 127;
         3'd6: l = 329;
         default: l = 256;
      endcase
      return l;
   endfunction

   // Monitor: sample the handshake before the edge, compare status after it.
   initial begin
      logic acc_s;
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         acc_s = bus.tvalid & bus.tready & !reset;
         if (meas) begin
            bp_cycles++;
            if (!bus.tready) bp_low++;
            if (!bus.tvalid && bus.tready) idle_ready++;
         end
         @(posedge clk);
         #1;
         if (acc_s) begin
            if (sb_q.size() == 0) begin
               check_val("sb_empty", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check_val("pkt_count", 32'(pkt_count), 32'(e.pkt));
               check_val("err_count", 32'(err_count), 32'(e.err));
               check_val("err_flag",  32'(err_flag),  32'(e.flag));
               check_val("err_code",  32'(err_code),  32'(e.code));
            end
         end
      end
   end

   // Drive one beat from a negedge and hold it until accepted.
   task automatic drive_beat(input logic [15:0] d, input logic [KW-1:0] k, input logic last,
                             input logic flip, input logic [1:0] ecode);
      logic [DW-1:0] w;
      logic          acc;
      int            n;
      w = {LANES{d}};
      if (flip) w[5] = ~w[5];
      if (ecode != 2'd0) begin
         if (mdl.err != '1) mdl.err = mdl.err + 1'b1;
         if (!mdl.flag) begin
            mdl.flag = 1'b1;
            mdl.code = ecode;
         end
      end
      if (last && mdl.pkt != '1) mdl.pkt = mdl.pkt + 1'b1;
      sb_q.push_back(mdl);
      bus.tdata  = w;
      bus.tkeep  = k;
      bus.tlast  = last;
      bus.tvalid = 1'b1;
      acc = 1'b0;
      n   = 0;
      while (!acc) begin
         #3;
         acc = bus.tvalid & bus.tready;
         @(negedge clk);
         n++;
         if (!acc && n >= 100) begin
            check_val("accept_timeout", 32'(n), 32'd0);
            $fatal(1, "beat never accepted");
         end
      end
      bus.tvalid = 1'b0;
      bus.tlast  = 1'b0;
   endtask

   // Send the next packet of the sequence (optionally faulted or truncated).
   task automatic send_pkt(input int kind, input int max_beats);
      int            len, tot, part, nb;
      logic [KW-1:0] k;
      logic          last, flip;
      logic [1:0]    ec;
      len  = len_of(e_idx);
      tot  = (len + KW - 1) / KW;
      part = len % KW;
      nb   = (kind == K_EARLY) ? 1 : tot;
      if (max_beats < nb) nb = max_beats;
      for (int b = 1; b <= nb; b++) begin
         k    = '1;
         if (b == tot && part != 0) k = KW'((1 << part) - 1);
         last = (b == tot);
         flip = 1'b0;
         ec   = 2'd0;
         if (kind == K_DATA && b == 3)     begin flip = 1'b1; ec = 2'd1; end
         if (kind == K_KEEP && b == tot)   begin k = '1;      ec = 2'd2; end
         if (kind == K_EARLY && b == 1)    begin last = 1'b1; ec = 2'd3; end
         if (kind == K_NOLAST && b == tot) begin last = 1'b0; ec = 2'd3; end
         drive_beat(e_data, k, last, flip, ec);
         e_data = e_data + 16'd1;
      end
      $display("pkt idx=%0d len=%0d kind=%0d beats=%0d pkt_count=%0d err_count=%0d",
               e_idx, len, kind, nb, pkt_count, err_count);
      if (nb == tot || kind == K_EARLY) e_idx = e_idx + 3'd1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask

   task automatic model_restart();
      mdl    = '0;
      e_data = 16'd1;
      e_idx  = 3'd0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sb_q.delete();
      model_restart();
   endtask

   task automatic check_status(input string tag, input int p, input int e, input int f, input int c);
      check_val({tag, "_pkt"},  32'(pkt_count), 32'(p));
      check_val({tag, "_err"},  32'(err_count), 32'(e));
      check_val({tag, "_flag"}, 32'(err_flag),  32'(f));
      check_val({tag, "_code"}, 32'(err_code),  32'(c));
   endtask

   initial begin
      int n;
      reset      = 1'b1;
      enable     = 1'b0;
      bus.tvalid = 1'b0;
      bus.tdata  = '0;
      bus.tkeep  = '0;
      bus.tlast  = 1'b0;
      model_restart();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check_status("reset", 0, 0, 0, 0);
      check_val("reset_tready", 32'(bus.tready), 32'd0);
      @(negedge clk);
      check_val("idle_tready", 32'(bus.tready), 32'd0);

      // Clean traffic: two passes through the length table under backpressure.
      enable = 1'b1;
      meas   = 1'b1;
      for (int i = 0; i < 16; i++) send_pkt(K_CLEAN, 1000);
      meas = 1'b0;
      check_status("clean16", 16, 0, 0, 0);
      check_val("bp_low_in_range", 32'((bp_low * 100 >= bp_cycles * 15) && (bp_low * 100 <= bp_cycles * 35)), 32'd1);
      check_val("ready_without_valid", 32'(idle_ready > 0), 32'd1);
      $display("backpressure low=%0d of %0d cycles", bp_low, bp_cycles);

      // Corrupted data on beat 3 of the 1021-byte packet.
      do_reset();
      for (int i = 0; i < 8; i++) send_pkt((i == 2) ? K_DATA : K_CLEAN, 1000);
      check_status("data_err", 8, 1, 1, 1);

      // Full keep mask on the short tail beat of the 18-byte packet.
      do_reset();
      send_pkt(K_KEEP, 1000);
      send_pkt(K_CLEAN, 1000);
      check_status("keep_err", 2, 1, 1, 2);

      // Early tlast, then a missing tlast with resync.
      do_reset();
      send_pkt(K_CLEAN, 1000);
      send_pkt(K_EARLY, 1000);
      send_pkt(K_CLEAN, 1000);
      send_pkt(K_NOLAST, 1000);
      send_pkt(K_CLEAN, 1000);
      check_status("len_err", 4, 2, 1, 3);

      // Reset in the middle of a packet, then restart from packet 0.
      send_pkt(K_CLEAN, 2);
      do_reset();
      #1;
      check_status("midreset", 0, 0, 0, 0);
      check_val("midreset_tready", 32'(bus.tready), 32'd0);
      send_pkt(K_CLEAN, 1000);
      send_pkt(K_CLEAN, 1000);
      check_status("after_reset", 2, 0, 0, 0);

      // Enable dropped mid-packet: tready falls at once, counts are kept.
      send_pkt(K_CLEAN, 5);
      n = 0;
      while (bus.tready !== 1'b1 && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      check_val("ready_before_drop", 32'(bus.tready), 32'd1);
      enable = 1'b0;
      #1;
      check_val("drop_tready", 32'(bus.tready), 32'd0);
      repeat (3) @(negedge clk);
      check_val("off_tready", 32'(bus.tready), 32'd0);
      check_status("dropped", 2, 0, 0, 0);
      enable = 1'b1;
      model_restart();
      mdl.pkt = 2;
      send_pkt(K_CLEAN, 1000);
      send_pkt(K_CLEAN, 1000);
      check_status("reenable", 4, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end
endmodule
